axi_fifo_master_port: RTL and testbench



---
 rtl/axi_fifo_master_port.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_fifo_master_port.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_fifo_master_port.sv
// rtl/axi_fifo_master_port.sv - AXI4 master end of the CDC bridge, slave clock domain
//
// Pops AR/AW/W entries from first-word-fall-through CDC FIFOs, replays them as
// an AXI4 master on the local bus, and pushes R/B beats into the return FIFOs.
// One read and one write may be outstanding at a time, each with its own FSM.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ar_/aw_/w_ not_empty, r_data    FIFO heads (FWFT), ar/aw {id,addr,len,size,burst}, w {data,strb,last}
//   ar_/aw_/w_ rd_en                pop strobes, one cycle per entry
//   r_/b_ not_full, wr_en, w_data   return FIFOs, r {id,data,resp,last}, b {id,resp}
//   AR*/R*/AW*/W*/B*                AXI4 master channels
//   rd_busy, wr_busy                FSM not idle
//   wlast_err                       sticky: W entry last bit disagreed with the beat counter
module axi_fifo_master_port #(
    parameter  int ID_W   = 8,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int A_W    = ID_W + ADDR_W + 9,
    localparam int R_W    = ID_W + DATA_W + 3,
    localparam int STRB_W = DATA_W / 8,
    localparam int W_W    = DATA_W + STRB_W + 1,
    localparam int B_W    = ID_W + 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ar_not_empty,
    input  logic [A_W-1:0]    ar_r_data,
    output logic              ar_rd_en,
    input  logic              aw_not_empty,
    input  logic [A_W-1:0]    aw_r_data,
    output logic              aw_rd_en,
    input  logic              w_not_empty,
    input  logic [W_W-1:0]    w_r_data,
    output logic              w_rd_en,

    input  logic              r_not_full,
    output logic              r_wr_en,
    output logic [R_W-1:0]    r_w_data,
    input  logic              b_not_full,
    output logic              b_wr_en,
    output logic [B_W-1:0]    b_w_data,

    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,

    input  logic [ID_W-1:0]   RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,

    output logic [ID_W-1:0]   AWID,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [3:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,

    output logic [DATA_W-1:0] WDATA,
    output logic [STRB_W-1:0] WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,

    input  logic [ID_W-1:0]   BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,

    output logic              rd_busy,
    output logic              wr_busy,
    output logic              wlast_err
);

    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;

    rd_state_t  rd_state;
    wr_state_t  wr_state;
    logic       active;
    logic [3:0] beat_cnt;
    logic       r_hs;
    logic       w_hs;
    logic       b_hs;
    logic       w_head_last;

    // Pops are combinational on not_empty, so they must be held off while reset
    // is asserted; this flop clears asynchronously and rises on the first clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    // Read path: R beats pass straight through to the R FIFO.
    assign ar_rd_en = active && (rd_state == RD_IDLE) && ar_not_empty;
    assign RREADY   = (rd_state == RD_DATA) && r_not_full;
    assign r_hs     = RVALID && RREADY;
    assign r_wr_en  = r_hs;
    assign r_w_data = {RID, RDATA, RRESP, RLAST};
    assign rd_busy  = (rd_state != RD_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            ARVALID  <= 1'b0;
            ARID     <= '0;
            ARADDR   <= '0;
            ARLEN    <= '0;
            ARSIZE   <= '0;
            ARBURST  <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_rd_en) begin
                        {ARID, ARADDR, ARLEN, ARSIZE, ARBURST} <= ar_r_data;
                        ARVALID  <= 1'b1;
                        rd_state <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (ARREADY) begin
                        ARVALID  <= 1'b0;
                        rd_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    // Returning to idle forces one idle cycle before the next pop.
                    if (r_hs && RLAST) begin
                        rd_state <= RD_IDLE;
                    end
                end
                default: begin
                    rd_state <= RD_IDLE;
                    ARVALID  <= 1'b0;
                end
            endcase
        end
    end

    // Write path: W data/strobe come straight from the FIFO head; WLAST comes
    // from the beat counter, not from the entry, so a bad entry cannot
    // shorten or lengthen the burst.
    assign w_head_last = w_r_data[0];
    assign aw_rd_en    = active && (wr_state == WR_IDLE) && aw_not_empty;
    assign WVALID      = (wr_state == WR_DATA) && w_not_empty;
    assign WLAST       = (wr_state == WR_DATA) && (beat_cnt == AWLEN);
    assign WDATA       = w_r_data[W_W-1 -: DATA_W];
    assign WSTRB       = w_r_data[STRB_W:1];
    assign w_hs        = WVALID && WREADY;
    assign w_rd_en     = w_hs;
    assign BREADY      = (wr_state == WR_RESP) && b_not_full;
    assign b_hs        = BVALID && BREADY;
    assign b_wr_en     = b_hs;
    assign b_w_data    = {BID, BRESP};
    assign wr_busy     = (wr_state != WR_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state  <= WR_IDLE;
            AWVALID   <= 1'b0;
            AWID      <= '0;
            AWADDR    <= '0;
            AWLEN     <= '0;
            AWSIZE    <= '0;
            AWBURST   <= '0;
            beat_cnt  <= '0;
            wlast_err <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_rd_en) begin
                        {AWID, AWADDR, AWLEN, AWSIZE, AWBURST} <= aw_r_data;
                        AWVALID  <= 1'b1;
                        beat_cnt <= '0;
                        wr_state <= WR_ADDR;
                    end
                end
                WR_ADDR: begin
                    if (AWREADY) begin
                        AWVALID  <= 1'b0;
                        wr_state <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        // With AWLEN=15 the counter wraps only on the final beat,
                        // after which it is no longer looked at.
                        beat_cnt <= beat_cnt + 4'd1;
                        if (w_head_last != WLAST) begin
                            wlast_err <= 1'b1;
                        end
                        if (WLAST) begin
                            wr_state <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        wr_state <= WR_IDLE;
                    end
                end
                default: begin
                    wr_state <= WR_IDLE;
                    AWVALID  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_fifo_master_port.sv
// tb/tb_axi_fifo_master_port.sv - self-checking bench for axi_fifo_master_port
module tb_axi_fifo_master_port;

    localparam int A_W = 49;
    localparam int R_W = 43;
    localparam int W_W = 37;
    localparam int B_W = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           ar_not_empty, aw_not_empty, w_not_empty;
    logic [A_W-1:0] ar_r_data, aw_r_data;
    logic [W_W-1:0] w_r_data;
    logic           ar_rd_en, aw_rd_en, w_rd_en;
    logic           r_not_full, b_not_full, r_wr_en, b_wr_en;
    logic [R_W-1:0] r_w_data;
    logic [B_W-1:0] b_w_data;
    logic [7:0]     ARID, AWID, RID, BID;
    logic [31:0]    ARADDR, AWADDR, RDATA, WDATA;
    logic [3:0]     ARLEN, AWLEN, WSTRB;
    logic [2:0]     ARSIZE, AWSIZE;
    logic [1:0]     ARBURST, AWBURST, RRESP, BRESP;
    logic           ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic           AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic           rd_busy, wr_busy, wlast_err;

    axi_fifo_master_port dut (
        .clk(clk), .rst_n(rst_n),
        .ar_not_empty(ar_not_empty), .ar_r_data(ar_r_data), .ar_rd_en(ar_rd_en),
        .aw_not_empty(aw_not_empty), .aw_r_data(aw_r_data), .aw_rd_en(aw_rd_en),
        .w_not_empty(w_not_empty), .w_r_data(w_r_data), .w_rd_en(w_rd_en),
        .r_not_full(r_not_full), .r_wr_en(r_wr_en), .r_w_data(r_w_data),
        .b_not_full(b_not_full), .b_wr_en(b_wr_en), .b_w_data(b_w_data),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .rd_busy(rd_busy), .wr_busy(wr_busy), .wlast_err(wlast_err)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // FIFO models, logs and slave state
    logic [A_W-1:0] ar_q[$];
    logic [A_W-1:0] aw_q[$];
    logic [W_W-1:0] w_q[$];
    logic [R_W-1:0] r_log[$];
    logic [B_W-1:0] b_log[$];
    logic [W_W-1:0] w_log[$];

    logic           s_rd_act = 1'b0, s_aw_done = 1'b0, s_b_pend = 1'b0;
    logic [7:0]     s_rd_id = '0, s_wr_id = '0;
    logic [3:0]     s_rd_len = '0;
    int             s_rd_beat = 0;
    logic [31:0]    s_rd_base = '0;
    logic [1:0]     s_rresp = '0, s_bresp = '0;
    int             ar_delay = 0, aw_delay = 0, ar_seen = 0, aw_seen = 0;
    logic           ar_hold = 1'b0;
    logic [A_W-1:0] ar_held = '0, ar_fields = '0, aw_fields = '0;
    int             r_block = 0, blk_at = -1, blk_len = 0, blk_cycles = 0;
    int             viol = 0, cnt_pops = 0, cnt_wb = 0, cyc_n = 0;
    int             t_ar_pop, t_ar_pop2, t_arvalid, t_aw_pop, t_awvalid, t_aw_hs, t_wvalid, t_rlast;

    function automatic logic [A_W-1:0] pack_a(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
        return {id, addr, len, 3'd2, 2'b01};
    endfunction

    function automatic logic [W_W-1:0] pack_w(input logic [31:0] d, input logic last);
        return {d, 4'hF, last};
    endfunction

    task automatic clear();
        r_log.delete(); b_log.delete(); w_log.delete();
        viol = 0; cnt_pops = 0; cnt_wb = 0; blk_cycles = 0;
        t_ar_pop = -1; t_ar_pop2 = -1; t_arvalid = -1; t_aw_pop = -1;
        t_awvalid = -1; t_aw_hs = -1; t_wvalid = -1; t_rlast = -1;
    endtask

    task automatic drive();
        ar_not_empty = (ar_q.size() != 0);
        ar_r_data    = ar_not_empty ? ar_q[0] : '0;
        aw_not_empty = (aw_q.size() != 0);
        aw_r_data    = aw_not_empty ? aw_q[0] : '0;
        w_not_empty  = (w_q.size() != 0);
        w_r_data     = w_not_empty ? w_q[0] : '0;
        r_not_full   = (r_block == 0);
        b_not_full   = 1'b1;
        ARREADY      = (ar_seen >= ar_delay);
        AWREADY      = (aw_seen >= aw_delay);
        WREADY       = 1'b1;
        RVALID       = s_rd_act;
        RID          = s_rd_id;
        RDATA        = s_rd_base + 32'(s_rd_beat);
        RRESP        = s_rresp;
        RLAST        = s_rd_act && (s_rd_beat == int'(s_rd_len));
        BVALID       = s_b_pend;
        BID          = s_wr_id;
        BRESP        = s_bresp;
    endtask

    // One clock: drive, sample mid-cycle, update the models, advance.
    task automatic cyc();
        logic [A_W-1:0] ar_cur;
        drive();
        #1;
        ar_cur = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
        if (ar_rd_en && !ar_not_empty) viol++;
        if (aw_rd_en && !aw_not_empty) viol++;
        if (w_rd_en && !w_not_empty) viol++;
        if (r_wr_en && !r_not_full) viol++;
        if (b_wr_en && !b_not_full) viol++;
        if (RREADY && !r_not_full) viol++;
        if (WVALID && !s_aw_done) viol++;
        if (WVALID && !w_not_empty) viol++;
        if (w_rd_en != (WVALID && WREADY)) viol++;
        if (r_wr_en != (RVALID && RREADY)) viol++;
        if (b_wr_en != (BVALID && BREADY)) viol++;
        if (ARVALID) begin
            if (ar_hold && (ar_cur != ar_held)) viol++;
            ar_held = ar_cur;
            ar_hold = !ARREADY;
        end
        if (!r_not_full) blk_cycles++;
        if (ar_rd_en || aw_rd_en || w_rd_en) cnt_pops++;
        if (WVALID || BREADY) cnt_wb++;
        if (ar_rd_en) begin
            if (t_ar_pop < 0) t_ar_pop = cyc_n;
            else if (t_ar_pop2 < 0) t_ar_pop2 = cyc_n;
        end
        if (ARVALID && t_arvalid < 0) t_arvalid = cyc_n;
        if (aw_rd_en && t_aw_pop < 0) t_aw_pop = cyc_n;
        if (AWVALID && t_awvalid < 0) t_awvalid = cyc_n;
        if (AWVALID && AWREADY && t_aw_hs < 0) t_aw_hs = cyc_n;
        if (WVALID && t_wvalid < 0) t_wvalid = cyc_n;
        if (r_wr_en && RLAST && t_rlast < 0) t_rlast = cyc_n;
        if (r_wr_en) r_log.push_back(r_w_data);
        if (b_wr_en) b_log.push_back(b_w_data);
        if (w_rd_en) w_log.push_back({WDATA, WSTRB, WLAST});
        // slave read side
        if (RVALID && RREADY) begin
            if (RLAST) s_rd_act = 1'b0;
            else s_rd_beat++;
        end
        if (ARVALID && ARREADY) begin
            s_rd_act = 1'b1; s_rd_id = ARID; s_rd_len = ARLEN; s_rd_beat = 0;
            ar_fields = ar_cur; ar_seen = 0;
        end else if (ARVALID) begin
            ar_seen++;
        end
        // slave write side
        if (AWVALID && AWREADY) begin
            s_aw_done = 1'b1; s_wr_id = AWID; aw_seen = 0;
            aw_fields = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST};
        end else if (AWVALID) begin
            aw_seen++;
        end
        if (WVALID && WREADY && WLAST) begin
            s_aw_done = 1'b0; s_b_pend = 1'b1;
        end else if (BVALID && BREADY) begin
            s_b_pend = 1'b0;
        end
        if (ar_rd_en && ar_q.size() != 0) void'(ar_q.pop_front());
        if (aw_rd_en && aw_q.size() != 0) void'(aw_q.pop_front());
        if (w_rd_en && w_q.size() != 0) void'(w_q.pop_front());
        if (r_block > 0) r_block--;
        if (blk_at >= 0 && r_log.size() == blk_at) begin
            r_block = blk_len; blk_at = -1;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic run_idle(input string name, input int max);
        bit done = 1'b0;
        for (int n = 0; n < max && !done; n++) begin
            cyc();
            done = (ar_q.size() == 0) && (aw_q.size() == 0) && !rd_busy && !wr_busy && !s_rd_act && !s_b_pend;
        end
        check({name, "_timeout"}, 64'(!done), 64'(0));
    endtask

    task automatic check_rlog(input string name, input logic [7:0] id, input logic [31:0] d0,
                              input logic [1:0] resp, input int len);
        int mis = 0;
        check({name, "_rcount"}, 64'(r_log.size()), 64'(len + 1));
        foreach (r_log[k]) begin
            if (r_log[k] !== {id, d0 + 32'(k), resp, (k == len)}) mis++;
        end
        check({name, "_rorder"}, 64'(mis), 64'(0));
    endtask

    typedef struct {
        logic [7:0]     id;
        logic [31:0]    addr;
        logic [3:0]     len;
        logic [31:0]    d0;
        logic [1:0]     resp;
        int             dly;
        logic [R_W-1:0] exp_first;
        logic [R_W-1:0] exp_last;
    } rd_vec_t;

    typedef struct {
        logic [7:0]     id;
        logic [31:0]    addr;
        logic [3:0]     len;
        logic [31:0]    d0;
        logic [1:0]     resp;
        int             dly;
        int             bad_beat;
        logic [B_W-1:0] exp_b;
        logic           exp_err;
    } wr_vec_t;

    rd_vec_t rv[3];
    wr_vec_t wv[3];

    initial begin
        logic [R_W-1:0] rfirst;
        logic [R_W-1:0] rlast_v;
        logic [B_W-1:0] bval;
        int mis;

        rv[0] = '{8'h05, 32'h0000_1000, 4'd0, 32'hDEAD_BEEF, 2'b00, 0,
                  {8'h05, 32'hDEAD_BEEF, 2'b00, 1'b1}, {8'h05, 32'hDEAD_BEEF, 2'b00, 1'b1}};
        rv[1] = '{8'hA7, 32'h2000_0040, 4'd3, 32'h1111_0000, 2'b00, 2,
                  {8'hA7, 32'h1111_0000, 2'b00, 1'b0}, {8'hA7, 32'h1111_0003, 2'b00, 1'b1}};
        rv[2] = '{8'hFF, 32'hFFFF_FFFC, 4'd15, 32'h8000_0000, 2'b10, 0,
                  {8'hFF, 32'h8000_0000, 2'b10, 1'b0}, {8'hFF, 32'h8000_000F, 2'b10, 1'b1}};
        wv[0] = '{8'h03, 32'h0000_0100, 4'd3, 32'h0000_00A0, 2'b00, 0, -1, 10'h00C, 1'b0};
        wv[1] = '{8'hC5, 32'h4000_0000, 4'd15, 32'h7700_0000, 2'b11, 2, -1, 10'h317, 1'b0};
        wv[2] = '{8'h01, 32'h0000_0200, 4'd1, 32'h0000_0B00, 2'b00, 0, 0, 10'h004, 1'b1};

        // reset state, with FIFO heads and responses presented
        clear();
        ar_q.push_back(pack_a(8'h99, 32'h1234_5678, 4'd2));
        aw_q.push_back(pack_a(8'h98, 32'h1234_5678, 4'd2));
        w_q.push_back(pack_w(32'h1, 1'b0));
        drive();
        RVALID = 1'b1; BVALID = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pops", 64'({ar_rd_en, aw_rd_en, w_rd_en}), 64'(0));
        check("rst_valid_ready", 64'({ARVALID, AWVALID, WVALID, RREADY, BREADY}), 64'(0));
        check("rst_pushes_status", 64'({r_wr_en, b_wr_en, rd_busy, wr_busy, wlast_err}), 64'(0));
        check("rst_ar_fields", 64'({ARID, ARADDR, ARLEN}), 64'(0));
        check("rst_aw_fields", 64'({AWID, AWADDR, AWLEN}), 64'(0));
        ar_q.delete(); aw_q.delete(); w_q.delete();
        drive();
        rst_n = 1'b1;
        repeat (2) cyc();

        // read vectors
        for (int i = 0; i < 3; i++) begin
            clear();
            ar_delay = rv[i].dly; s_rresp = rv[i].resp; s_rd_base = rv[i].d0;
            ar_q.push_back(pack_a(rv[i].id, rv[i].addr, rv[i].len));
            run_idle($sformatf("rd%0d", i), 100);
            rfirst  = (r_log.size() > 0) ? r_log[0] : '1;
            rlast_v = (r_log.size() > 0) ? r_log[r_log.size()-1] : '1;
            check($sformatf("rd%0d_first", i), 64'(rfirst), 64'(rv[i].exp_first));
            check($sformatf("rd%0d_last", i), 64'(rlast_v), 64'(rv[i].exp_last));
            check_rlog($sformatf("rd%0d", i), rv[i].id, rv[i].d0, rv[i].resp, int'(rv[i].len));
            check($sformatf("rd%0d_ar_fields", i), 64'(ar_fields), 64'(pack_a(rv[i].id, rv[i].addr, rv[i].len)));
            check($sformatf("rd%0d_arvalid_lat", i), 64'(t_arvalid - t_ar_pop), 64'(1));
            check($sformatf("rd%0d_protocol", i), 64'(viol), 64'(0));
            check($sformatf("rd%0d_busy", i), 64'(rd_busy), 64'(0));
        end
        ar_delay = 0;

        // write vectors (the last-bit mismatch one is last: wlast_err is sticky)
        for (int i = 0; i < 3; i++) begin
            clear();
            aw_delay = wv[i].dly; s_bresp = wv[i].resp;
            aw_q.push_back(pack_a(wv[i].id, wv[i].addr, wv[i].len));
            for (int k = 0; k <= int'(wv[i].len); k++)
                w_q.push_back(pack_w(wv[i].d0 + 32'(k), (k == int'(wv[i].len)) ^ (k == wv[i].bad_beat)));
            run_idle($sformatf("wr%0d", i), 100);
            mis = 0;
            foreach (w_log[k])
                if (w_log[k] !== {wv[i].d0 + 32'(k), 4'hF, (k == int'(wv[i].len))}) mis++;
            check($sformatf("wr%0d_wcount", i), 64'(w_log.size()), 64'(int'(wv[i].len) + 1));
            check($sformatf("wr%0d_wbeats", i), 64'(mis), 64'(0));
            bval = (b_log.size() > 0) ? b_log[0] : '1;
            check($sformatf("wr%0d_bcount", i), 64'(b_log.size()), 64'(1));
            check($sformatf("wr%0d_bdata", i), 64'(bval), 64'(wv[i].exp_b));
            check($sformatf("wr%0d_wlast_err", i), 64'(wlast_err), 64'(wv[i].exp_err));
            check($sformatf("wr%0d_aw_fields", i), 64'(aw_fields), 64'(pack_a(wv[i].id, wv[i].addr, wv[i].len)));
            check($sformatf("wr%0d_awvalid_lat", i), 64'(t_awvalid - t_aw_pop), 64'(1));
            check($sformatf("wr%0d_w_after_aw", i), 64'(t_wvalid > t_aw_hs), 64'(1));
            check($sformatf("wr%0d_protocol", i), 64'(viol), 64'(0));
        end
        aw_delay = 0; s_bresp = 2'b00;

        // concurrency: AR and AW heads appear together
        clear();
        s_rresp = 2'b01; s_rd_base = 32'hCAFE_0000;
        ar_q.push_back(pack_a(8'h11, 32'h0000_5000, 4'd2));
        aw_q.push_back(pack_a(8'h22, 32'h0000_6000, 4'd1));
        w_q.push_back(pack_w(32'h0000_0001, 1'b0));
        w_q.push_back(pack_w(32'h0000_0002, 1'b1));
        run_idle("conc", 100);
        check("conc_same_pop", 64'(t_ar_pop == t_aw_pop && t_ar_pop >= 0), 64'(1));
        check_rlog("conc", 8'h11, 32'hCAFE_0000, 2'b01, 2);
        bval = (b_log.size() > 0) ? b_log[0] : '1;
        check("conc_bdata", 64'(bval), 64'(10'h088));
        check("conc_wlast_err_sticky", 64'(wlast_err), 64'(1));
        check("conc_protocol", 64'(viol), 64'(0));

        // backpressure: R FIFO full for 5 cycles during a len=7 read
        clear();
        s_rresp = 2'b00; s_rd_base = 32'h0000_0100;
        blk_at = 2; blk_len = 5;
        ar_q.push_back(pack_a(8'h5A, 32'h0000_7000, 4'd7));
        run_idle("bp", 100);
        check("bp_block_cycles", 64'(blk_cycles), 64'(5));
        check_rlog("bp", 8'h5A, 32'h0000_0100, 2'b00, 7);
        check("bp_protocol", 64'(viol), 64'(0));

        // back-to-back reads: at least one idle cycle after RLAST
        clear();
        s_rd_base = 32'h0000_0A00;
        ar_q.push_back(pack_a(8'h31, 32'h0000_8000, 4'd1));
        ar_q.push_back(pack_a(8'h32, 32'h0000_9000, 4'd0));
        run_idle("b2b", 100);
        check("b2b_idle_gap", 64'(t_ar_pop2 > t_rlast && t_rlast >= 0), 64'(1));
        check("b2b_rcount", 64'(r_log.size()), 64'(3));
        check("b2b_protocol", 64'(viol), 64'(0));

        // reset during beat 2 of a len=3 write
        clear();
        aw_q.push_back(pack_a(8'h44, 32'h0000_3000, 4'd3));
        for (int k = 0; k < 4; k++) w_q.push_back(pack_w(32'h5000 + 32'(k), k == 3));
        for (int n = 0; n < 50 && w_log.size() < 1; n++) cyc();
        check("rstm_reach_beat2", 64'(w_log.size()), 64'(1));
        drive();
        #1;
        check("rstm_wvalid_before", 64'({WVALID, wr_busy}), 64'(2'b11));
        rst_n = 1'b0;
        #1;
        check("rstm_async_outputs",
              64'({WVALID, w_rd_en, AWVALID, BREADY, wr_busy, rd_busy, wlast_err, aw_rd_en, ar_rd_en, RREADY, ARVALID}),
              64'(0));
        check("rstm_async_aw_fields", 64'({AWID, AWADDR, AWLEN}), 64'(0));
        s_aw_done = 1'b0; s_b_pend = 1'b0; s_rd_act = 1'b0; aw_seen = 0; ar_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear();
        repeat (10) cyc();
        check("rstm_no_pops", 64'(cnt_pops), 64'(0));
        check("rstm_no_wvalid_bready", 64'(cnt_wb), 64'(0));
        check("rstm_wlast_err_cleared", 64'(wlast_err), 64'(0));
        check("rstm_protocol", 64'(viol), 64'(0));
        w_q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
